// File: rtl/serial_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_rx_pkg
// Shared types and helpers for the serial receive path:
//   rx_state_t  - receiver FSM encoding (SHIFT collecting bits, HOLD word ready)
//   len_width() - width of a fill counter able to hold 0..depth inclusive
// -----------------------------------------------------------------------------
package serial_rx_pkg;

    typedef enum logic [0:0] {
        SHIFT = 1'b0,
        HOLD  = 1'b1
    } rx_state_t;

    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rx_word_queue.sv
// -----------------------------------------------------------------------------
// rx_word_queue
// Circular word buffer with a registered read port.
//   clk, rst_n  - clock, asynchronous active-low reset
//   push_i      - write wdata_i at the tail (caller guarantees space or a
//                 same-cycle pop)
//   pop_i       - remove the head word into rdata_o (caller guarantees non-empty)
//   flush_i     - synchronous clear of pointers and fill level, wins over all
//   wdata_i     - word to push
//   rdata_o     - last popped word, held between pops
//   len_o       - words currently stored
//   full_o      - len_o == DEPTH
//   empty_o     - len_o == 0
// -----------------------------------------------------------------------------
module rx_word_queue
    import serial_rx_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 8,
    localparam int LEN_W  = len_width(DEPTH),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              push_s;
    logic              pop_s;

    // Qualify requests and compute next pointer, level and read-data state.
    always_comb begin
        push_s  = push_i & ~flush_i;
        pop_s   = pop_i & ~flush_i;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        len_d   = len_q;
        rdata_d = rdata_q;
        if (flush_i) begin
            wptr_d = {PTR_W{1'b0}};
            rptr_d = {PTR_W{1'b0}};
            len_d  = {LEN_W{1'b0}};
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push_s) begin
                wptr_d = wptr_q + PTR_W'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d  = rptr_q + PTR_W'(1);
                rdata_d = mem_q[rptr_q];
            end else begin
                rptr_d  = rptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   len_d = len_q + LEN_W'(1);
                2'b01:   len_d = len_q - LEN_W'(1);
                default: len_d = len_q;
            endcase
        end
    end

    // Pointer, level and read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            len_q   <= len_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array; a push at full with a same-edge pop reads the old head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;
    assign len_o   = len_q;
    assign full_o  = (len_q == LEN_W'(DEPTH));
    assign empty_o = (len_q == {LEN_W{1'b0}});

endmodule

// File: rtl/serial_rx_fifo.sv
// -----------------------------------------------------------------------------
// serial_rx_fifo
// Serial-to-parallel receiver feeding a word queue, single clock.
//   clock1M    - clock, rising edge
//   reset      - asynchronous active-low reset
//   data_in    - serial bit, taken when write_in=1 and status_out=0
//   write_in   - bit strobe
//   status_out - 1 while a complete word waits for queue space
//   dequeue_in - pop request, ignored when empty
//   flush_in   - synchronous clear of receiver and queue
//   data_out   - last popped word
//   data_valid - one-cycle pulse when data_out updates
//   len_out    - words queued; full / empty decoded from it
// -----------------------------------------------------------------------------
module serial_rx_fifo
    import serial_rx_pkg::*;
#(
    parameter int  DATA_W    = 8,
    parameter int  DEPTH     = 8,
    parameter int  MSB_FIRST = 1,
    localparam int LEN_W     = len_width(DEPTH)
) (
    input  logic              clock1M,
    input  logic              reset,
    input  logic              data_in,
    input  logic              write_in,
    output logic              status_out,
    input  logic              dequeue_in,
    input  logic              flush_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [LEN_W-1:0]  len_out,
    output logic              full,
    output logic              empty
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              valid_q, valid_d;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;

    // Pop is qualified here so the HOLD state can see a same-edge pop at full.
    assign pop_s = dequeue_in & ~empty_s & ~flush_in;

    // Receiver next-state: bit collection, hand-off to the queue, flush.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        push_s  = 1'b0;
        valid_d = pop_s;
        if (flush_in) begin
            state_d = SHIFT;
            count_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                SHIFT: begin
                    if (write_in) begin
                        if (MSB_FIRST != 0) begin
                            shift_d = {shift_q[DATA_W-2:0], data_in};
                        end else begin
                            shift_d = {data_in, shift_q[DATA_W-1:1]};
                        end
                        if (count_q == LAST_BIT) begin
                            state_d = HOLD;
                            count_d = {CNT_W{1'b0}};
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = SHIFT;
                    end
                end
                HOLD: begin
                    if (!full_s || pop_s) begin
                        push_s  = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = SHIFT;
                    count_d = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Receiver state, bit counter, shift register and valid pulse.
    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            state_q <= SHIFT;
            count_q <= {CNT_W{1'b0}};
            shift_q <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    rx_word_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk     (clock1M),
        .rst_n   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (flush_in),
        .wdata_i (shift_q),
        .rdata_o (data_out),
        .len_o   (len_out),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign status_out = (state_q == HOLD);
    assign data_valid = valid_q;
    assign full       = full_s;
    assign empty      = empty_s;

endmodule

// File: doc/serial_rx_fifo.md
# serial_rx_fifo

Parametrised serial-to-parallel receive path with built-in word queue, single clock domain. Replaces the deserializer, queue and clock-divider chain of the current receive path. Bit acceptance and queue access are qualified by strobes on one clock. Adds configurable word width, queue depth and bit order, real back-pressure, simultaneous push/pop, and synchronous flush.

## Interface

- DATA_W, 8, word width in bits (≥2)
- DEPTH, 8, queue depth in words (power of two, ≥2)
- MSB_FIRST, 1, 1: first received bit lands in bit DATA_W-1; 0: first bit lands in bit 0
- clock1M  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset
- data_in  input  1  serial bit, sampled when write_in=1
- write_in  input  1  bit strobe; one bit accepted per cycle while status_out=0
- status_out  output  1  1 = receiver holding a complete word, write_in ignored
- dequeue_in  input  1  pop request
- flush_in  input  1  synchronous clear of receiver and queue
- data_out  output  DATA_W  last popped word, registered
- data_valid  output  1  one-cycle pulse when data_out updates
- len_out  output  $clog2(DEPTH+1)  words currently queued
- full  output  1  len_out == DEPTH
- empty  output  1  len_out == 0

## Operation

- Receiver FSM states: SHIFT (collecting bits), HOLD (word complete, awaiting queue space).
- SHIFT: on each edge with write_in=1, shift data_in into the shift register per MSB_FIRST and increment bit count. On the edge accepting bit DATA_W, go to HOLD and reset count to 0.
- HOLD: status_out=1 and write_in ignored. Push the word on the first edge where the queue is not full, or is full with a pop that is accepted on that same edge. Return to SHIFT on that edge.
- Queue: circular buffer with read/write pointers of width $clog2(DEPTH) that wrap modulo DEPTH. len_out is maintained as a counter.
- Pop accepted when dequeue_in=1 and not empty. data_out takes the head word and data_valid=1 on the following cycle. Pop on empty is ignored: data_out holds, no pulse.
- Simultaneous push and pop: both take effect and len_out is unchanged. This is legal at full and at any non-empty level.
- flush_in=1 overrides everything on that edge. Pointers, len_out and bit count go to 0 and FSM goes to SHIFT. Any pending pop is discarded: data_valid=0 and data_out holds. Bits presented that cycle are dropped.
- No overflow is possible, since back-pressure is via status_out. Sender must not present bits while status_out=1.

## Timing

- Reset (reset=0, async) values: FSM=SHIFT, count=0, pointers=0, len_out=0, empty=1, full=0, status_out=0, data_out=0, data_valid=0.
- Last bit accepted on edge N: status_out=1 after N. If space exists, push on edge N+1, len_out increments after N+1, and status_out=0 after N+1.
- Next word's first bit is accepted no earlier than edge N+2. Peak throughput is one word per DATA_W+1 cycles.
- Pop on edge M: data_out and data_valid valid after M. data_valid drops after M+1 unless another pop occurs.
- full, empty and status_out are decoded from registered state; no combinational input-to-output paths.
- Reset assertion mid-word discards the partial word and queue contents immediately.

## Structure

- Package serial_rx_pkg: rx_state_t enum {SHIFT, HOLD}.
- Package serial_rx_pkg: function for the len width, clog2(DEPTH+1).
- One sub-module, rx_word_queue (parametrised DATA_W/DEPTH).
  - Inputs: push, pop, flush, wdata.
  - Outputs: rdata, len, full, empty.
- The top level holds the FSM and shift register.

## Test plan

- MSB_FIRST=1, DATA_W=8: bits 1,0,1,0,0,1,0,1 on consecutive cycles -> status_out=1 for one cycle, len_out=1. Then dequeue -> data_out=0xA5 with a one-cycle data_valid.
- MSB_FIRST=0, same bit sequence -> popped word 0xA5 bit-reversed = 0xA5 (palindrome); repeat with 1,1,0,0,0,0,0,0 -> 0x03.
- Fill DEPTH=8 with words 0x00..0x07 -> full=1. Ninth word keeps status_out=1 with no push. One dequeue returns 0x00 and the push happens on that same edge, so len_out stays 8. Drain returns 0x01..0x08 in order, verifying pointer wrap.
- Dequeue on empty -> no data_valid, data_out unchanged, len_out=0. Simultaneous push+pop at len_out=3 -> len_out stays 3.
- flush_in after 4 bits with len_out=5 -> len_out=0 and empty=1. A new 8-bit word is then received correctly from bit count 0.
- Assert reset low mid-word and mid-queue -> all outputs at reset values asynchronously. A post-release word is received correctly.
